// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer for a combinational ALU: registers a request onto the ALU inputs,
// waits a per-class latency, captures the 64-bit result and returns it over valid/ready.
module alu_sequencer #(
    parameter int unsigned SIMPLE_CYCLES = 1,
    parameter int unsigned MUL_CYCLES    = 4,
    parameter int unsigned DIV_CYCLES    = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_opcode,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [4:0]  alu_opcode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [63:0] alu_z,
    output logic [31:0] z_hi,
    output logic [31:0] z_lo,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_error,
    output logic        busy
);

    localparam int unsigned MaxSd = (SIMPLE_CYCLES > MUL_CYCLES) ? SIMPLE_CYCLES : MUL_CYCLES;
    localparam int unsigned MaxCycles = (MaxSd > DIV_CYCLES) ? MaxSd : DIV_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles) + 1;

    localparam logic [4:0] OpAdd  = 5'b01100;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b01010;
    localparam logic [4:0] OpOr   = 5'b01011;
    localparam logic [4:0] OpNot  = 5'b10010;
    localparam logic [4:0] OpNeg  = 5'b10001;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b00001;
    localparam logic [4:0] OpRor  = 5'b01000;
    localparam logic [4:0] OpRol  = 5'b01001;
    localparam logic [4:0] OpShl  = 5'b00111;
    localparam logic [4:0] OpShr  = 5'b00101;
    localparam logic [4:0] OpShra = 5'b00110;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [4:0]        op_q, op_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       zhi_q, zhi_d;
    logic [31:0]       zlo_q, zlo_d;
    logic              err_q, err_d;
    logic              legal;
    logic [CntW-1:0]   latency_m1;

    always_comb begin
        legal      = 1'b0;
        latency_m1 = CntW'(SIMPLE_CYCLES - 1);
        unique case (req_opcode)
            OpAdd, OpSub, OpAnd, OpOr, OpNot, OpNeg,
            OpRor, OpRol, OpShl, OpShr, OpShra: legal = 1'b1;
            OpMul: begin
                legal      = 1'b1;
                latency_m1 = CntW'(MUL_CYCLES - 1);
            end
            OpDiv: begin
                legal      = 1'b1;
                latency_m1 = CntW'(DIV_CYCLES - 1);
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        zhi_d   = zhi_q;
        zlo_d   = zlo_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d = req_opcode;
                    a_d  = req_a;
                    b_d  = req_b;
                    // Errors skip EXEC entirely and leave the previous result in place.
                    if (!legal || (req_opcode == OpDiv && req_b == 32'd0)) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        cnt_d   = latency_m1;
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                if (cnt_q == '0) begin
                    zhi_d   = alu_z[63:32];
                    zlo_d   = alu_z[31:0];
                    err_d   = 1'b0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            zhi_q   <= '0;
            zlo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign rsp_valid  = (state_q == StResp);
    assign busy       = (state_q != StIdle);
    assign alu_opcode = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign z_hi       = zhi_q;
    assign z_lo       = zlo_q;
    assign rsp_error  = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU on the alu_* port, scoreboard of
// expected results pushed at request time and popped when the response appears.
module tb_alu_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [63:0] alu_z;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_error;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    logic [31:0] zhi_m, zlo_m;

    localparam logic [4:0] OP_TABLE [13] = '{5'b01100, 5'b00100, 5'b01010, 5'b01011, 5'b10010,
                                             5'b10001, 5'b01111, 5'b00001, 5'b01000, 5'b01001,
                                             5'b00111, 5'b00101, 5'b00110};

    alu_sequencer #(
        .SIMPLE_CYCLES(1),
        .MUL_CYCLES   (4),
        .DIV_CYCLES   (8)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opcode(req_opcode),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_opcode(alu_opcode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_z     (alu_z),
        .z_hi      (z_hi),
        .z_lo      (z_lo),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_error (rsp_error),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [5:0]  s;
        logic [31:0] r;
        s = {1'b0, b[4:0]};
        r = 32'd0;
        case (op)
            5'b01100: r = a + b;
            5'b00100: r = a - b;
            5'b01010: r = a & b;
            5'b01011: r = a | b;
            5'b10010: r = ~a;
            5'b10001: r = -a;
            5'b01000: r = (a >> s) | (a << (6'd32 - s));
            5'b01001: r = (a << s) | (a >> (6'd32 - s));
            5'b00111: r = a << s;
            5'b00101: r = a >> s;
            5'b00110: r = $unsigned($signed(a) >>> s);
            5'b01111: return $unsigned($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
            5'b00001: begin
                if (b == 32'd0) return 64'd0;
                return {$unsigned($signed(a) % $signed(b)), $unsigned($signed(a) / $signed(b))};
            end
            default: r = 32'd0;
        endcase
        return {32'd0, r};
    endfunction

    always_comb alu_z = ref_alu(alu_opcode, alu_a, alu_b);

    function automatic bit is_legal(input logic [4:0] op);
        foreach (OP_TABLE[i]) if (OP_TABLE[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Expected result and acceptance-to-rsp_valid distance in cycles; updates the z model.
    task automatic push_expect(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] z;
        if (!is_legal(op) || (op == 5'b00001 && b == 32'd0)) begin
            e.hi = zhi_m; e.lo = zlo_m; e.err = 1'b1; e.lat = 1;
        end else begin
            z = ref_alu(op, a, b);
            e.hi = z[63:32]; e.lo = z[31:0]; e.err = 1'b0;
            e.lat = (op == 5'b01111) ? 5 : (op == 5'b00001) ? 9 : 2;
            zhi_m = e.hi; zlo_m = e.lo;
        end
        exp_q.push_back(e);
    endtask

    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        exp_t e;
        int n;
        int bad;
        push_expect(op, a, b);
        @(negedge clock);
        req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clock); n++; end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s accept: req_ready=%b required 1", name, req_ready);
        end
        @(posedge clock); #1 req_valid = 1'b0;
        n = 0; bad = 0;
        while (n < 50) begin
            @(negedge clock); n++;
            if (rsp_valid) break;
            if (req_ready !== 1'b0 || busy !== 1'b1 || alu_opcode !== op ||
                alu_a !== a || alu_b !== b) bad++;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (n !== e.lat) begin
            n_fail++; $display("FAIL %s latency: got %0d required %0d", name, n, e.lat);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL %s exec_hold: %0d bad EXEC cycles required 0", name, bad);
        end
        n_checks++;
        if (alu_opcode !== op || alu_a !== a || alu_b !== b) begin
            n_fail++;
            $display("FAIL %s alu_regs: got %h/%h/%h required %h/%h/%h", name, alu_opcode,
                     alu_a, alu_b, op, a, b);
        end
        n_checks++;
        if ({z_hi, z_lo} !== {e.hi, e.lo} || rsp_error !== e.err || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s result: got z=%h_%h err=%b busy=%b required z=%h_%h err=%b busy=1",
                     name, z_hi, z_lo, rsp_error, busy, e.hi, e.lo, e.err);
        end
        @(negedge clock);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s release: rsp_valid=%b req_ready=%b required 0/1", name, rsp_valid,
                     req_ready);
        end
    endtask

    task automatic test_reset();
        int seen;
        reset_n = 1'b0; req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b0;
        #1;
        n_checks++;
        if ({alu_opcode, alu_a, alu_b, z_hi, z_lo, rsp_valid, rsp_error, busy} !== '0 ||
            req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_values: outputs not at reset, busy=%b req_ready=%b",
                               busy, req_ready);
        end
        @(negedge clock); reset_n = 1'b1;
        // Start a DIV and pull reset asynchronously while it is executing.
        @(negedge clock);
        req_valid = 1'b1; req_opcode = 5'b00001; req_a = 32'd17; req_b = 32'd5;
        @(posedge clock); #1 req_valid = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (busy !== 1'b1 || alu_a !== 32'd17) begin
            n_fail++; $display("FAIL reset_pre: busy=%b alu_a=%h required 1/11", busy, alu_a);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({alu_opcode, alu_a, alu_b, z_hi, z_lo, rsp_valid, rsp_error, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: op=%h a=%h b=%h z=%h_%h v=%b e=%b busy=%b required 0",
                     alu_opcode, alu_a, alu_b, z_hi, z_lo, rsp_valid, rsp_error, busy);
        end
        @(negedge clock); @(negedge clock); reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
        end
        seen = 0;
        repeat (20) begin @(negedge clock); if (rsp_valid !== 1'b0) seen++; end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL reset_no_rsp: rsp_valid high %0d cycles required 0", seen);
        end
        zhi_m = 32'd0; zlo_m = 32'd0;
    endtask

    task automatic test_add();
        run_op("add", 5'b01100, 32'h5, 32'h3);
        n_checks++;
        if (z_lo !== 32'h8 || z_hi !== 32'h0) begin
            n_fail++; $display("FAIL add_const: got %h_%h required 0_8", z_hi, z_lo);
        end
    endtask

    task automatic test_mul();
        run_op("mul", 5'b01111, 32'h8000_0000, 32'h4);
        n_checks++;
        if ({z_hi, z_lo} !== 64'hFFFF_FFFE_0000_0000) begin
            n_fail++; $display("FAIL mul_const: got %h_%h required fffffffe_00000000", z_hi, z_lo);
        end
    endtask

    task automatic test_div();
        run_op("div_zero", 5'b00001, 32'd17, 32'd0);
        run_op("div", 5'b00001, 32'd17, 32'd5);
        n_checks++;
        if (z_hi !== 32'd2 || z_lo !== 32'd3) begin
            n_fail++; $display("FAIL div_const: got %h_%h required 2_3", z_hi, z_lo);
        end
    endtask

    task automatic test_illegal();
        run_op("illegal", 5'b11111, 32'h1234, 32'h5678);
        run_op("or", 5'b01011, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        n_checks++;
        if (z_lo !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL or_const: got %h required ffffffff", z_lo);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int n;
        int bad;
        logic [31:0] hz, lz;
        push_expect(5'b01010, 32'hFF00_FF00, 32'h0FF0_0FF0);
        push_expect(5'b00100, 32'd10, 32'd3);
        @(negedge clock);
        req_valid = 1'b1; req_opcode = 5'b01010; req_a = 32'hFF00_FF00; req_b = 32'h0FF0_0FF0;
        rsp_ready = 1'b0;
        @(posedge clock); #1;
        req_opcode = 5'b00100; req_a = 32'd10; req_b = 32'd3;
        n = 0;
        while (n < 50) begin @(negedge clock); n++; if (rsp_valid) break; end
        e = exp_q.pop_front();
        n_checks++;
        if (n !== e.lat || {z_hi, z_lo} !== {e.hi, e.lo} || rsp_error !== e.err) begin
            n_fail++; $display("FAIL bp_and: lat=%0d z=%h_%h err=%b required %0d %h_%h %b", n,
                               z_hi, z_lo, rsp_error, e.lat, e.hi, e.lo, e.err);
        end
        hz = z_hi; lz = z_lo; bad = 0;
        repeat (10) begin
            @(negedge clock);
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || z_hi !== hz || z_lo !== lz ||
                alu_opcode !== 5'b01010) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL bp_stall: %0d unstable cycles required 0", bad);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || alu_opcode !== 5'b01010) begin
            n_fail++; $display("FAIL bp_handshake: v=%b rdy=%b op=%h required 0/1/0a", rsp_valid,
                               req_ready, alu_opcode);
        end
        @(posedge clock); #1 req_valid = 1'b0;
        n = 0;
        while (n < 50) begin @(negedge clock); n++; if (rsp_valid) break; end
        e = exp_q.pop_front();
        n_checks++;
        if (alu_opcode !== 5'b00100 || n !== e.lat || {z_hi, z_lo} !== {e.hi, e.lo} ||
            rsp_error !== e.err) begin
            n_fail++; $display("FAIL bp_sub: op=%h lat=%0d z=%h_%h required 04 %0d %h_%h",
                               alu_opcode, n, z_hi, z_lo, e.lat, e.hi, e.lo);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [4:0] op;
        for (int i = 0; i < 12; i++) begin
            op = OP_TABLE[$urandom_range(12, 0)];
            run_op("random", op, $urandom, $urandom);
        end
    endtask

    initial begin
        zhi_m = 32'd0; zlo_m = 32'd0;
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle controller that sequences the combinational ALU. It accepts one operation per valid/ready request and registers the opcode and operands onto the ALU inputs. It then waits a per-class latency so the slow MUL/DIV paths can be constrained as multicycle paths. Finally it captures the 64-bit result into ZHI/ZLO and returns it on a valid/ready response channel, flagging illegal opcodes and divide-by-zero.

Parameters:
SIMPLE_CYCLES, 1, cycles the ALU is held in EXEC for ADD/SUB/AND/OR/NOT/NEG/shifts/rotates (must be >=1)
MUL_CYCLES, 4, EXEC cycles for MUL (>=1)
DIV_CYCLES, 8, EXEC cycles for DIV (>=1)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_opcode  in  5  operation code
req_a  in  32  operand A
req_b  in  32  operand B
alu_opcode  out  5  registered opcode driven to ALU
alu_a  out  32  registered operand A to ALU
alu_b  out  32  registered operand B to ALU
alu_z  in  64  ALU result (Zin)
z_hi  out  32  captured result bits [63:32]
z_lo  out  32  captured result bits [31:0]
rsp_valid  out  1  result/status available
rsp_ready  in  1  consumer takes response
rsp_error  out  1  illegal opcode or DIV by zero; qualified by rsp_valid
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE; alu_opcode/alu_a/alu_b=0; z_hi/z_lo=0; rsp_valid=0; rsp_error=0; busy=0; cycle counter=0. Reset mid-operation aborts the op with no response; outputs reach reset values immediately, without waiting for a clock edge.
- Legal opcodes: ADD 01100, SUB 00100, AND 01010, OR 01011, NOT 10010, NEG 10001, MUL 01111, DIV 00001, ROR 01000, ROL 01001, SHL 00111, SHR 00101, SHRA 00110. All other codes are illegal.
- States: IDLE, EXEC, RESP.
- IDLE: req_ready=1 (combinational from state only, never from req_valid). On an edge with req_valid&req_ready:
  - Always: latch req_opcode/req_a/req_b into alu_opcode/alu_a/alu_b.
  - Illegal opcode, or DIV with req_b==0: go to RESP with rsp_error=1; z_hi/z_lo keep their previous values.
  - Otherwise: go to EXEC with counter = latency-1, where latency is MUL_CYCLES for MUL, DIV_CYCLES for DIV, else SIMPLE_CYCLES.
- EXEC: req_ready=0. alu_* are held stable. Counter decrements each edge. On the edge where counter==0: z_hi<=alu_z[63:32], z_lo<=alu_z[31:0], rsp_error<=0, go to RESP. Non-MUL/DIV results are zero-extended by the ALU, so z_hi=0 for those.
- RESP: rsp_valid=1; z_hi/z_lo/rsp_error are held stable until the handshake. On rsp_valid&rsp_ready go to IDLE; rsp_valid drops the next cycle. No request is accepted in the same cycle as the response handshake.
- Timing (SIMPLE_CYCLES=1):
  - Request accepted at edge k; rsp_valid high after edge k+1.
  - With rsp_ready held at 1: handshake at edge k+2; req_ready high after edge k+2.
  - Minimum throughput is one operation per latency+2 cycles.
- Error path: rsp_valid high after edge k+1 (no EXEC cycles).
- rsp_ready held low: remain in RESP indefinitely; req_valid is ignored (req_ready=0).
- alu_* retain their last values in IDLE/RESP; they change only on request acceptance.
- Counter width = clog2(max(SIMPLE_CYCLES,MUL_CYCLES,DIV_CYCLES))+1; no wrap is possible.

Test Plan:
- Reset: hold reset_n=0 mid-EXEC of a DIV -> all outputs 0 and busy=0 asynchronously; after release, req_ready=1 and no rsp_valid ever appears.
- ADD A=0x00000005 B=0x00000003, rsp_ready=1 -> rsp_valid exactly 2 cycles after acceptance; z_lo=0x00000008, z_hi=0, rsp_error=0.
- MUL A=0x80000000 B=0x00000004 (MUL_CYCLES=4) -> rsp_valid 5 cycles after acceptance; {z_hi,z_lo}=ALU product (signed: 0xFFFFFFFE_00000000); busy=1 throughout; req_ready=0 during EXEC.
- DIV A=17 B=0 -> rsp_valid the cycle after acceptance; rsp_error=1; z_hi/z_lo unchanged from previous op. Then DIV A=17 B=5 -> after 8 EXEC cycles, z_hi/z_lo = ALU remainder/quotient halves (2/3), rsp_error=0.
- Illegal opcode 11111 -> rsp_error=1 with no EXEC; the next legal OR 0xF0F0F0F0|0x0F0F0F0F gives z_lo=0xFFFFFFFF.
- Backpressure: rsp_ready=0 for 10 cycles after an AND completes, with req_valid=1 asserted throughout -> rsp_valid and z stay stable, no second request is accepted; on rsp_ready=1 the handshake completes and the pending request is accepted the following cycle.
